// File: rtl/matrix_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_pkg
//  Description : Shared types and sizing helpers for the matrix_pwm driver.
//  Revision    : 1.0 - initial release
// ============================================================================
package matrix_pkg;

  // Scan phase within one row period.
  typedef enum logic {
    BLANK = 1'b0,
    PWM   = 1'b1
  } phase_t;

  // Counter width for a range of n values; never narrower than 1 bit.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Pixel address width.
  function automatic int addr_w(input int rows, input int cols);
    return cw(rows * cols);
  endfunction

  // Clocks per row period: blanking plus every PWM step.
  function automatic int row_period(input int bpp, input int slot_clks, input int blank_clks);
    return blank_clks + (1 << bpp) * slot_clks;
  endfunction

  // Clocks per frame while scanning continuously.
  function automatic int frame_clks(input int rows, input int bpp, input int slot_clks,
                                    input int blank_clks);
    return rows * row_period(bpp, slot_clks, blank_clks);
  endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_fb.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_fb
//  Description : Double-buffered pixel store. Host writes the back bank, the
//                scanner reads one full row of the front bank.
//  Revision    : 1.0 - initial release
// ============================================================================
module matrix_fb
  import matrix_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int BPP  = 4
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           wr_en,
  input  logic [addr_w(ROWS, COLS)-1:0]  wr_addr,
  input  logic [BPP-1:0]                 wr_data,
  input  logic                           swap,
  input  logic [cw(ROWS)-1:0]            rd_row,
  output logic [COLS*BPP-1:0]            rd_data
);

  localparam int AW = addr_w(ROWS, COLS);

  // One packed word per row keeps the scanner read a simple row select.
  logic [COLS*BPP-1:0] bank_a [ROWS];
  logic [COLS*BPP-1:0] bank_b [ROWS];
  // sel=0: A is front, B is back. sel=1: B is front, A is back.
  logic                sel;

  // Bank storage, write port and front/back select. Addresses past the
  // last pixel match no entry and are dropped.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sel <= 1'b0;
      for (int r = 0; r < ROWS; r++) begin
        bank_a[r] <= '0;
        bank_b[r] <= '0;
      end
    end else begin
      if (swap) begin
        sel <= ~sel;
      end
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          if (wr_en && (wr_addr == AW'(r * COLS + c))) begin
            if (sel) begin
              bank_a[r][c*BPP +: BPP] <= wr_data;
            end else begin
              bank_b[r][c*BPP +: BPP] <= wr_data;
            end
          end
        end
      end
    end
  end

  assign rd_data = sel ? bank_b[rd_row] : bank_a[rd_row];

endmodule
`default_nettype wire

// File: rtl/matrix_pwm.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_pwm
//  Description : Row-scanned LED matrix driver with per-pixel grey-scale PWM,
//                row blanking and a tear-free double-buffered framebuffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module matrix_pwm
  import matrix_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int BPP        = 4,
  parameter int SLOT_CLKS  = 16,
  parameter int BLANK_CLKS = 8
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           en,
  input  logic                           wr_en,
  input  logic [addr_w(ROWS, COLS)-1:0]  wr_addr,
  input  logic [BPP-1:0]                 wr_data,
  input  logic                           swap_req,
  output logic                           swap_ack,
  output logic                           frame_start,
  output logic [ROWS-1:0]                row,
  output logic [COLS-1:0]                col
);

  localparam int RW = cw(ROWS);
  localparam int BW = cw(BLANK_CLKS);
  localparam int SW = cw(SLOT_CLKS);

  localparam logic [RW-1:0]  ROW_LAST   = RW'(ROWS - 1);
  localparam logic [BW-1:0]  BLANK_LAST = BW'(BLANK_CLKS - 1);
  localparam logic [SW-1:0]  SLOT_LAST  = SW'(SLOT_CLKS - 1);
  localparam logic [BPP-1:0] PWM_LAST   = {BPP{1'b1}};

  phase_t         phase, phase_nx;
  logic [BW-1:0]  blank_cnt, blank_nx;
  logic [SW-1:0]  slot_cnt, slot_nx;
  logic [BPP-1:0] pwm_cnt, pwm_nx;
  logic [RW-1:0]  row_idx, row_nx;

  logic                pending;
  logic                swapped;
  logic                frame_first;
  logic                frame_last;
  logic                swap_fire;
  logic [COLS*BPP-1:0] row_data;
  logic [COLS-1:0]     col_pwm;

  assign frame_first = (phase == BLANK) && (blank_cnt == '0) && (row_idx == '0);
  assign frame_last  = (phase == PWM) && (row_idx == ROW_LAST) &&
                       (pwm_cnt == PWM_LAST) && (slot_cnt == SLOT_LAST);
  // A request arriving on the swap point itself is taken by that swap.
  assign swap_fire   = en && frame_last && (pending || swap_req);

  matrix_fb #(
    .ROWS (ROWS),
    .COLS (COLS),
    .BPP  (BPP)
  ) u_fb (
    .clk     (clk),
    .resetn  (resetn),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .swap    (swap_fire),
    .rd_row  (row_idx),
    .rd_data (row_data)
  );

  // Scan state register: phase plus nested blank/slot/pwm/row counters.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      phase     <= BLANK;
      blank_cnt <= '0;
      slot_cnt  <= '0;
      pwm_cnt   <= '0;
      row_idx   <= '0;
    end else begin
      phase     <= phase_nx;
      blank_cnt <= blank_nx;
      slot_cnt  <= slot_nx;
      pwm_cnt   <= pwm_nx;
      row_idx   <= row_nx;
    end
  end

  // Next scan state; everything holds while the scan is disabled.
  always_comb begin
    phase_nx = phase;
    blank_nx = blank_cnt;
    slot_nx  = slot_cnt;
    pwm_nx   = pwm_cnt;
    row_nx   = row_idx;
    if (en) begin
      case (phase)
        BLANK: begin
          if (blank_cnt == BLANK_LAST) begin
            blank_nx = '0;
            phase_nx = PWM;
          end else begin
            blank_nx = blank_cnt + BW'(1);
          end
        end
        PWM: begin
          if (slot_cnt == SLOT_LAST) begin
            slot_nx = '0;
            if (pwm_cnt == PWM_LAST) begin
              pwm_nx   = '0;
              phase_nx = BLANK;
              row_nx   = (row_idx == ROW_LAST) ? '0 : row_idx + RW'(1);
            end else begin
              pwm_nx = pwm_cnt + BPP'(1);
            end
          end else begin
            slot_nx = slot_cnt + SW'(1);
          end
        end
        default: phase_nx = BLANK;
      endcase
    end
  end

  // Column sinks for the current step: a pixel conducts while its value
  // exceeds the PWM step, so value v lights for v of the 2^BPP steps.
  always_comb begin
    col_pwm = '1;
    for (int c = 0; c < COLS; c++) begin
      col_pwm[c] = ~(row_data[c*BPP +: BPP] > pwm_cnt);
    end
  end

  // Swap bookkeeping: pending collapses repeated requests; swapped holds
  // the acknowledge until it can be issued together with frame_start.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pending <= 1'b0;
      swapped <= 1'b0;
    end else begin
      if (swap_fire) begin
        pending <= 1'b0;
      end else if (swap_req) begin
        pending <= 1'b1;
      end
      if (swap_fire) begin
        swapped <= 1'b1;
      end else if (en && frame_first) begin
        swapped <= 1'b0;
      end
    end
  end

  // Registered drive outputs, one clock behind the scan state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      row         <= '0;
      col         <= '1;
      frame_start <= 1'b0;
      swap_ack    <= 1'b0;
    end else begin
      frame_start <= en && frame_first;
      swap_ack    <= en && frame_first && swapped;
      if (!en || (phase == BLANK)) begin
        row <= '0;
        col <= '1;
      end else begin
        row <= ROWS'(1) << row_idx;
        col <= col_pwm;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_matrix_pwm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_matrix_pwm
//  Description : Self-checking bench for matrix_pwm (4x4, 2 bpp, 2 clk slots,
//                1 clk blank) with a frame-position reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_pwm;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int BPP   = 2;
  localparam int SLOT  = 2;
  localparam int BLANK = 1;
  localparam int NPIX  = ROWS * COLS;
  localparam int RP    = BLANK + (1 << BPP) * SLOT;   // 9
  localparam int FRAME = ROWS * RP;                    // 36

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       en = 1'b0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [1:0] wr_data = '0;
  logic       swap_req = 1'b0;
  logic       swap_ack;
  logic       frame_start;
  logic [3:0] row;
  logic [3:0] col;

  int errors = 0;
  int checks = 0;

  matrix_pwm #(
    .ROWS       (ROWS),
    .COLS       (COLS),
    .BPP        (BPP),
    .SLOT_CLKS  (SLOT),
    .BLANK_CLKS (BLANK)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .en          (en),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .swap_req    (swap_req),
    .swap_ack    (swap_ack),
    .frame_start (frame_start),
    .row         (row),
    .col         (col)
  );

  always #5 clk = ~clk;

  // Reference model: position within the frame, two pixel buffers,
  // which one is shown, and the swap request / acknowledge flags.
  int         m_pos;
  int         m_front;
  bit         m_pending;
  bit         m_swapped;
  logic [1:0] m_buf [2][NPIX];

  typedef struct {
    logic [3:0] addr;
    logic [1:0] data;
    logic [3:0] exp_row;
    int         col_bit;
    int         on_clks;
  } vec_t;

  vec_t tbl [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_front = 0; m_pending = 0; m_swapped = 0;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < NPIX; i++) m_buf[b][i] = '0;
  endtask

  // One clock: predict outputs from the model, advance the model, clock
  // the DUT, then compare just after the edge.
  task automatic tick();
    logic [3:0] er, ec;
    logic       ef, ea;
    int         r, o, step;
    er = '0; ec = '1; ef = 1'b0; ea = 1'b0;
    if (en) begin
      r  = m_pos / RP;
      o  = m_pos % RP;
      ef = (m_pos == 0);
      ea = ef && m_swapped;
      if (ef) m_swapped = 0;
      if (o >= BLANK) begin
        step = (o - BLANK) / SLOT;
        er   = 4'(1 << r);
        for (int c = 0; c < COLS; c++)
          ec[c] = !(int'(m_buf[m_front][r*COLS + c]) > step);
      end
    end
    if (wr_en) m_buf[1 - m_front][wr_addr] = wr_data;
    if (en && (m_pos == FRAME - 1) && (m_pending || swap_req)) begin
      m_front   = 1 - m_front;
      m_pending = 0;
      m_swapped = 1;
    end else if (swap_req) begin
      m_pending = 1;
    end
    if (en) m_pos = (m_pos + 1) % FRAME;
    @(posedge clk);
    #1;
    check("row", 32'(row), 32'(er));
    check("col", 32'(col), 32'(ec));
    check("frame_start", 32'(frame_start), 32'(ef));
    check("swap_ack", 32'(swap_ack), 32'(ea));
  endtask

  task automatic wait_ack(input int bound);
    int n;
    n = 0;
    while (n < bound) begin
      tick();
      n++;
      if (swap_ack) break;
    end
    if (!swap_ack) check("ack_timeout", 32'(0), 32'(1));
  endtask

  task automatic wait_fs(input int bound);
    int n;
    n = 0;
    while (n < bound) begin
      tick();
      n++;
      if (frame_start) break;
    end
    if (!frame_start) check("fs_timeout", 32'(0), 32'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_row"}, 32'(row), 32'h0);
    check({tag, "_col"}, 32'(col), 32'hF);
    check({tag, "_ack"}, 32'(swap_ack), 32'h0);
    check({tag, "_fs"},  32'(frame_start), 32'h0);
  endtask

  initial begin
    int acks, lit, interval;

    // Single lit pixel per entry: clocks lit = value * SLOT in its row.
    tbl[0] = '{addr: 4'd5,  data: 2'd3, exp_row: 4'b0010, col_bit: 1, on_clks: 6};
    tbl[1] = '{addr: 4'd0,  data: 2'd1, exp_row: 4'b0001, col_bit: 0, on_clks: 2};
    tbl[2] = '{addr: 4'd15, data: 2'd2, exp_row: 4'b1000, col_bit: 3, on_clks: 4};
    tbl[3] = '{addr: 4'd10, data: 2'd0, exp_row: 4'b0100, col_bit: 2, on_clks: 0};
    tbl[4] = '{addr: 4'd6,  data: 2'd3, exp_row: 4'b0010, col_bit: 2, on_clks: 6};

    // Reset state.
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    resetn = 1'b1;
    en     = 1'b1;

    // Idle scan: all off, frame_start every FRAME clocks.
    wait_fs(FRAME + 2);
    interval = 0;
    do begin
      tick();
      interval++;
    end while (!frame_start && interval < 3 * FRAME);
    check("frame_period", 32'(interval), 32'(FRAME));

    // Table: fill back buffer with one lit pixel, swap, measure lit clocks.
    for (int k = 0; k < 5; k++) begin
      for (int a = 0; a < NPIX; a++) begin
        wr_en   = 1'b1;
        wr_addr = 4'(a);
        wr_data = (4'(a) == tbl[k].addr) ? tbl[k].data : 2'd0;
        tick();
      end
      wr_en    = 1'b0;
      swap_req = 1'b1;
      tick();
      swap_req = 1'b0;
      wait_ack(2 * FRAME + 2);
      check("ack_with_fs", 32'(frame_start), 32'(1));
      lit = 0;
      for (int i = 0; i < FRAME - 1; i++) begin
        tick();
        if (row == tbl[k].exp_row && col[tbl[k].col_bit] == 1'b0) lit++;
      end
      check("vec_lit_clks", 32'(lit), 32'(tbl[k].on_clks));
    end

    // Write without a swap: no ack for three frames, then exactly one.
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 2'd3;
    tick();
    wr_en = 1'b0;
    acks = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick();
      if (swap_ack) acks++;
    end
    check("no_swap_acks", 32'(acks), 32'(0));
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    acks = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      if (swap_ack) acks++;
    end
    check("late_swap_acks", 32'(acks), 32'(1));

    // Three requests in one frame, plus a write on the swap-point cycle.
    wait_fs(FRAME + 2);
    for (int i = 1; i <= 20; i++) begin
      swap_req = (i == 3 || i == 10 || i == 20);
      tick();
    end
    swap_req = 1'b0;
    while (m_pos != FRAME - 1) tick();
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 2'd2;
    tick();
    wr_en = 1'b0;
    acks = 0;
    lit  = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      if (swap_ack) acks++;
      if (i < FRAME && row == 4'b0010 && col[3] == 1'b0) lit++;
    end
    check("triple_req_acks", 32'(acks), 32'(1));
    check("swap_point_write", 32'(lit), 32'(4));

    // Enable dropped mid-row for 10 clocks stretches the frame by 10.
    wait_fs(FRAME + 2);
    interval = 0;
    for (int i = 0; i < 14; i++) begin tick(); interval++; end
    en = 1'b0;
    tick(); interval++;
    check("en_low_row", 32'(row), 32'h0);
    check("en_low_col", 32'(col), 32'hF);
    for (int i = 0; i < 9; i++) begin tick(); interval++; end
    en = 1'b1;
    do begin
      tick();
      interval++;
    end while (!frame_start && interval < 3 * FRAME);
    check("stretched_period", 32'(interval), 32'(FRAME + 10));

    // Randomised traffic against the model.
    for (int i = 0; i < 500; i++) begin
      en       = ($urandom_range(0, 7) != 0);
      wr_en    = ($urandom_range(0, 2) == 0);
      wr_addr  = 4'($urandom_range(0, NPIX - 1));
      wr_data  = 2'($urandom_range(0, 3));
      swap_req = ($urandom_range(0, 19) == 0);
      tick();
    end
    en = 1'b1; wr_en = 1'b0; swap_req = 1'b0;

    // Reset mid-frame with a swap pending.
    wait_fs(2 * FRAME + 2);
    for (int i = 0; i < 5; i++) tick();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    #2;
    resetn = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(posedge clk);
    #1;
    resetn = 1'b1;
    model_reset();
    acks = 0;
    lit  = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      if (swap_ack) acks++;
      if (col != 4'hF) lit++;
    end
    check("post_reset_acks", 32'(acks), 32'(0));
    check("post_reset_dark", 32'(lit), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/matrix_pwm.md
Name: matrix_pwm

Overview:
Parametrised row-scanned LED matrix driver with per-pixel grey-scale PWM and a double-buffered framebuffer. It replaces the fixed 4x4 on/off single-pixel scanner. All columns of one row are driven at once, with row blanking between rows. A host (CPU bus or pattern generator) writes pixels into the back buffer and requests a tear-free swap. The swap takes effect only at a frame boundary.

Parameters:
ROWS, 4, number of row (source) lines
COLS, 4, number of column (sink) lines
BPP, 4, brightness bits per pixel; 2^BPP PWM steps
SLOT_CLKS, 16, clocks per PWM step (>=1)
BLANK_CLKS, 8, clocks of all-off blanking at start of each row period (>=1)

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
en  in  1  scan enable; low = outputs blanked, scan counters hold
wr_en  in  1  back-buffer write strobe
wr_addr  in  clog2(ROWS*COLS)  pixel index = r*COLS + c
wr_data  in  BPP  pixel brightness, 0 = off
swap_req  in  1  request back/front swap (pulse or level)
swap_ack  out  1  one-cycle pulse when swap applied
frame_start  out  1  one-cycle pulse coincident with first clock of row 0 period
row  out  ROWS  row source drive, active-high, one-hot or zero
col  out  COLS  column sink drive, active-low

Behaviour:
- Reset (async assert, sync release): row=0, col=all 1s, swap_ack=0, frame_start=0, both buffers cleared to 0, swap pending cleared, all counters 0, front=buffer A.
- Counters: blank_cnt 0..BLANK_CLKS-1, then slot_cnt 0..SLOT_CLKS-1 nested inside pwm_cnt 0..2^BPP-1, then row_idx 0..ROWS-1 wrapping to 0.
- Row period = BLANK_CLKS + 2^BPP*SLOT_CLKS clocks. Frame = ROWS * row period.
- Outputs are registered, 1-clock latency from counter state.
- Blanking phase: row=0, col=all 1s.
- PWM phase: row=one-hot(row_idx). col[c]=0 iff front[row_idx*COLS+c] > pwm_cnt, so value v lights for v of 2^BPP steps. Max value lights (2^BPP-1)/2^BPP of the phase.
- Row with all pixels 0: row is still asserted, col stays all 1s.
- en=0: row=0, col=all 1s on the next clock; counters hold; no frame_start. en re-asserted: scan resumes from the held counters.
- Writes: wr_en updates the back buffer on the next edge. wr_addr >= ROWS*COLS is ignored. Front buffer is never written by the port.
- Swap: swap_req sets a pending flag (multiple requests collapse into one). At the last clock of the frame (row ROWS-1, last slot of last PWM step) with pending set and en=1, front/back select toggles and pending clears. swap_ack pulses on the next clock, coincident with frame_start.
- A write in the same cycle the swap is applied lands in the pre-swap back buffer, so it is visible in the new frame.
- swap_req in the same cycle as the swap point is absorbed into that swap.
- After a swap the new back buffer holds the old front contents. There is no copy; the host rewrites it fully.
- Reset mid-frame: outputs go to the reset values immediately; the frame restarts at row 0 with pending discarded.

Decomposition:
- Package matrix_pkg: functions/localparams for ADDR_W=clog2(ROWS*COLS), ROW_PERIOD, FRAME_CLKS; the phase enum {BLANK, PWM}.
- Sub-module matrix_fb: two ROWS*COLS*BPP register banks, write port, select bit, and a combinational read of one full row (COLS*BPP) for the scanner.
- The scanner, counters and swap control stay in matrix_pwm.

Test Plan (ROWS=4, COLS=4, BPP=2, SLOT_CLKS=2, BLANK_CLKS=1; row period 9 clocks, frame 36):
- Reset, en=1, no writes -> row cycles 0001,0010,0100,1000 each for 8 of 9 clocks with 1 blank clock between; col=1111 throughout; frame_start every 36 clocks.
- Write addr5=3, addr0=1, then swap_req -> after the next frame boundary: row 0010 has col=1101 for 6 of 8 PWM clocks; row 0001 has col=1110 for 2 clocks; swap_ack and frame_start pulse together.
- Write without swap_req -> outputs unchanged for 3 frames; swap_req then applies at the next boundary only.
- swap_req pulsed 3 times within one frame -> exactly one swap_ack; a write issued in the swap-point cycle appears in the new frame.
- Drop en mid-row for 10 clocks -> row=0, col=1111 within 1 clock; resumes at the same pwm/row position; frame period stretched by 10 clocks.
- Assert resetn low mid-frame with a swap pending -> outputs go to the reset values asynchronously; after release, display is all off and no swap_ack occurs.
